// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead add/subtract unit with valid/ready handshake on both sides.
// Optional signed-overflow output is enabled by defining CLA_OVERFLOW_FLAG_EN.
module cla_pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
`ifdef CLA_OVERFLOW_FLAG_EN
    ,
    output logic             out_overflow
`endif
);

    localparam int SLICE  = WIDTH / STAGES;
    localparam int GROUPS = SLICE / 4;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // 4-bit lookahead inside each group; group G/P combine into the carry of the next group.
    function automatic logic [SLICE:0] slice_add(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] sum;
        logic [3:0]       c;
        logic             gc;
        logic             grp_g;
        logic             grp_p;
        g   = a & b;
        p   = a ^ b;
        sum = '0;
        gc  = cin;
        for (int j = 0; j < GROUPS; j++) begin
            c[0] = gc;
            c[1] = g[4*j] | (p[4*j] & gc);
            c[2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc);
            c[3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                 | (p[4*j+2] & p[4*j+1] & p[4*j] & gc);
            grp_g = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p = &p[4*j +: 4];
            sum[4*j +: 4] = p[4*j +: 4] ^ c;
            gc = grp_g | (grp_p & gc);
        end
        return {gc, sum};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // REM: operand bits still to be added from this stage upward; DONE: sum bits finished here.
        localparam int REM  = WIDTH - k * SLICE;
        localparam int DONE = (k + 1) * SLICE;

        logic [REM-1:0]  a_cur;
        logic [REM-1:0]  b_cur;
        logic            cin_cur;
        logic            valid_cur;
        logic [SLICE:0]  res;
        logic [DONE-1:0] sum_next;
        logic            valid_q;
        logic            carry_q;
        logic [DONE-1:0] sum_q;

        if (k == 0) begin : g_first
            assign a_cur     = in_a;
            assign b_cur     = in_b ^ {WIDTH{in_sub}};
            assign cin_cur   = in_carry ^ in_sub;
            assign valid_cur = in_valid;
            assign sum_next  = res[SLICE-1:0];
        end else begin : g_next
            assign a_cur     = g_stage[k-1].g_fwd.a_q;
            assign b_cur     = g_stage[k-1].g_fwd.b_q;
            assign cin_cur   = g_stage[k-1].carry_q;
            assign valid_cur = g_stage[k-1].valid_q;
            assign sum_next  = {res[SLICE-1:0], g_stage[k-1].sum_q};
        end

        assign res = slice_add(a_cur[SLICE-1:0], b_cur[SLICE-1:0], cin_cur);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_cur;
                carry_q <= res[SLICE];
                sum_q   <= sum_next;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Skew registers: upper operand slices wait for their carry to arrive.
            logic [REM-SLICE-1:0] a_q;
            logic [REM-SLICE-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_cur[REM-1:SLICE];
                    b_q <= b_cur[REM-1:SLICE];
                end
            end
        end else begin : g_last
`ifdef CLA_OVERFLOW_FLAG_EN
            // Carry into the MSB is recovered as a^b'^sum at that bit.
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= a_cur[SLICE-1] ^ b_cur[SLICE-1] ^ res[SLICE-1] ^ res[SLICE];
                end
            end
`else
            // Overflow flag disabled: no register, no port.
`endif
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign out_sum   = g_stage[STAGES-1].sum_q;
    assign out_carry = g_stage[STAGES-1].carry_q;
`ifdef CLA_OVERFLOW_FLAG_EN
    assign out_overflow = g_stage[STAGES-1].g_last.ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Directed, table-driven bench for cla_pipelined_adder (WIDTH=16, STAGES via parameter S).
// Define CLA_OVERFLOW_FLAG_EN for both RTL and bench to exercise the overflow flag.
module tb_cla_pipelined_adder;

    parameter int S = 2;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_carry;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
`ifdef CLA_OVERFLOW_FLAG_EN
    logic         out_overflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_carry     (in_carry),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry)
`ifdef CLA_OVERFLOW_FLAG_EN
        ,
        .out_overflow (out_overflow)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    vec_t         vecs [10];
    logic [W-1:0] stream_op  [4];
    logic [W-1:0] stream_sum [4];
    logic         stream_cy  [4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_carry = cin;
        in_sub   = sub;
    endtask

    // One isolated beat into an empty pipe: latency, result and single-cycle valid pulse.
    task automatic runBeat(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic [W-1:0] sum,
                           input logic carry, input logic ovf);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(a, b, cin, sub);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " latency"}, lat, S);
        checkOutput({name, " sum"}, out_sum, sum);
        checkOutput({name, " carry"}, out_carry, carry);
`ifdef CLA_OVERFLOW_FLAG_EN
        checkOutput({name, " ovf"}, out_overflow, ovf);
`else
        if (ovf === 1'bx) $display("[TB] unexpected X in overflow column for %s", name);
`endif
        @(negedge clk);
        checkOutput({name, " valid pulse"}, out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        int got;
        int stall;
        int extra;
        bit stalled;

        vecs[0] = '{16'h000A, 16'h000F, 1'b1, 1'b0, 16'h001A, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[9] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

        stream_op[0] = 16'h0001; stream_sum[0] = 16'h0002; stream_cy[0] = 1'b0;
        stream_op[1] = 16'h0002; stream_sum[1] = 16'h0004; stream_cy[1] = 1'b0;
        stream_op[2] = 16'h0003; stream_sum[2] = 16'h0006; stream_cy[2] = 1'b0;
        stream_op[3] = 16'h8000; stream_sum[3] = 16'h0000; stream_cy[3] = 1'b1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_carry  = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_sum", out_sum, 0);
        checkOutput("reset out_carry", out_carry, 0);
        checkOutput("reset in_ready", in_ready, 1);
`ifdef CLA_OVERFLOW_FLAG_EN
        checkOutput("reset out_overflow", out_overflow, 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runBeat($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].sum, vecs[i].carry, vecs[i].ovf);
        end

        // Back-to-back stream with a 3-cycle downstream stall once the first result appears.
        sent    = 0;
        got     = 0;
        stall   = 0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && !stalled) begin
                stalled = 1'b1;
                stall   = 3;
            end
            out_ready = (stall == 0);
            if (sent < 4) applyStimulus(stream_op[sent], stream_op[sent], 1'b0, 1'b0);
            else          in_valid = 1'b0;
            #1;
            if (stall > 0) begin
                checkOutput("stall in_ready", in_ready, 0);
                checkOutput("stall out_valid", out_valid, 1);
                checkOutput("stall held sum", out_sum, stream_sum[0]);
                checkOutput("stall held carry", out_carry, stream_cy[0]);
                stall--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream sum %0d", got), out_sum, stream_sum[got]);
                checkOutput($sformatf("stream carry %0d", got), out_carry, stream_cy[got]);
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream count", got, 4);
        extra = 0;
        repeat (S + 3) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checkOutput("stream no duplicate", extra, 0);

        // Reset with beats in flight: everything in the pipe is discarded.
        @(negedge clk);
        applyStimulus(16'h0010, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(16'h0100, 16'h0200, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midreset out_valid", out_valid, 0);
        checkOutput("midreset out_sum", out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checkOutput("post-reset no result", extra, 0);
        runBeat("post-reset beat", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
